// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: the PC register, the F/D pipeline register and the
// instruction field slicer for a 32-bit RV32I-style in-order pipeline.
// Each cycle is one of three kinds: sequential, stall or redirect.
// Redirect takes priority over stall. A synchronous reset overrides both.
// Optional build macro: FD_PERF_CNT_EN adds the fetch_cnt, stall_cnt and
// flush_cnt performance counter outputs.
module fetch_decode_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        next_pc_sel,
  input  logic [31:0] jb_pc,
  output logic [31:0] im_addr,
  input  logic [31:0] im_rdata,
  output logic [31:0] F_pc,
  output logic [31:0] D_pc,
  output logic [31:0] D_inst,
  output logic [23:0] D_out,
  output logic        D_valid,
  output logic        D_illegal,
  output logic        E_flush
`ifdef FD_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    CYC_SEQ      = 2'd0,
    CYC_STALL    = 2'd1,
    CYC_REDIRECT = 2'd2
  } cyc_e;

  cyc_e        cyc;
  logic [31:0] redirect_pc;
  logic        opcode_ok;

  // Branch/jump targets are always halfword aligned, so bit 0 is cleared.
  assign redirect_pc = jb_pc & ~32'h0000_0001;

  // Classify the cycle; redirect wins over stall.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
    cyc = CYC_SEQ;
    if (!next_pc_sel) begin
      cyc = CYC_REDIRECT;
    end else if (stall) begin
      cyc = CYC_STALL;
    end
  end

  // PC register and F/D pipeline register update.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples the pre-edge values.
    if (rst) begin
      F_pc    <= RESET_PC;
      D_inst  <= NOP_INST;
      D_pc    <= 32'h0000_0000;
      D_valid <= 1'b0;
      E_flush <= 1'b0;
    end else begin
      unique case (cyc)
        CYC_REDIRECT: begin
          F_pc    <= redirect_pc;
          D_inst  <= NOP_INST;
          D_pc    <= 32'h0000_0000;
          D_valid <= 1'b0;
          E_flush <= 1'b1;
        end
        CYC_STALL: begin
          E_flush <= 1'b0;
        end
        default: begin
          F_pc    <= F_pc + 32'd4;
          D_inst  <= im_rdata;
          D_pc    <= F_pc;
          D_valid <= 1'b1;
          E_flush <= 1'b0;
        end
      endcase
    end
  end

  // The instruction memory is addressed directly by the fetch PC.
  assign im_addr = F_pc;

  // The decode word is a pure slice of the held instruction.
  assign D_out = {D_inst[30], D_inst[24:20], D_inst[19:15],
                  D_inst[14:12], D_inst[11:7], D_inst[6:2]};

  // Check the opcode against the supported major opcodes.
  always_comb begin
    opcode_ok = 1'b0;
    unique case (D_inst[6:2])
      5'b01100, 5'b00100, 5'b00000, 5'b11001, 5'b01000,
      5'b11000, 5'b01101, 5'b00101, 5'b11011: opcode_ok = 1'b1;
      default:                                opcode_ok = 1'b0;
    endcase
  end

  // An instruction is illegal only when it is real, so a bubble never is.
  assign D_illegal = D_valid & ((D_inst[1:0] != 2'b11) | ~opcode_ok);

`ifdef FD_PERF_CNT_EN
  // Exactly one counter advances in every non-reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= 32'd0;
      stall_cnt <= 32'd0;
      flush_cnt <= 32'd0;
    end else begin
      unique case (cyc)
        CYC_REDIRECT: flush_cnt <= flush_cnt + 32'd1;
        CYC_STALL:    stall_cnt <= stall_cnt + 32'd1;
        default:      fetch_cnt <= fetch_cnt + 32'd1;
      endcase
    end
  end
`endif

endmodule

// File: doc/fetch_decode_stage.md
FETCH_DECODE_STAGE -- requirements
Module: fetch_decode_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded on reset.
REQ-002 Parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), is the bubble instruction inserted into D.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 stall  input  1  hold PC and F/D register this cycle (load-use hazard from the controller).
REQ-006 next_pc_sel  input  1  0 = taken jump/branch resolved in E, redirect to jb_pc; 1 = sequential.
REQ-007 jb_pc  input  32  redirect target; bit 0 is forced to 0 internally.
REQ-008 im_addr  output  32  instruction memory address, equal to F_pc.
REQ-009 im_rdata  input  32  instruction word for im_addr, valid in the same cycle (asynchronous ROM).
REQ-010 F_pc  output  32  current fetch PC register.
REQ-011 D_pc  output  32  PC of the instruction held in D.
REQ-012 D_inst  output  32  raw instruction held in D.
REQ-013 D_out  output  24  packed decode word: [4:0]=inst[6:2], [9:5]=inst[11:7] rd, [12:10]=inst[14:12] f3, [17:13]=inst[19:15] rs1, [22:18]=inst[24:20] rs2, [23]=inst[30].
REQ-014 D_valid  output  1  D holds a real (non-bubble) instruction.
REQ-015 D_illegal  output  1  D_valid and inst[1:0]!=2'b11 or inst[6:2] not one of 01100,00100,00000,11001,01000,11000,01101,00101,11011.
REQ-016 E_flush  output  1  registered pulse telling the D/E register to load a bubble.

Function
REQ-017 D_out shall be a pure combinational slice of D_inst; no additional latency.
REQ-018 Sequential cycle (stall=0, next_pc_sel=1): F_pc <= F_pc+4; D_inst <= im_rdata; D_pc <= F_pc; D_valid <= 1.
REQ-019 Stall cycle (stall=1, next_pc_sel=1): F_pc, D_inst, D_pc, D_valid hold; E_flush <= 0.
REQ-020 Redirect cycle (next_pc_sel=0): F_pc <= {jb_pc[31:1],1'b0}; D_inst <= NOP_INST; D_pc <= 0; D_valid <= 0; E_flush <= 1.
REQ-021 Redirect shall take priority over stall when both are asserted in the same cycle.
REQ-022 E_flush shall be 1 for exactly the cycle following each redirect cycle and 0 otherwise; back-to-back redirects produce back-to-back pulses.
REQ-023 F_pc+4 shall wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000) with no flag.
REQ-024 im_addr shall always equal F_pc, including during stall and reset.
REQ-025 D_illegal shall be 0 whenever D_valid=0.

Reset
REQ-026 While rst=1 at posedge clk: F_pc <= RESET_PC, D_inst <= NOP_INST, D_pc <= 0, D_valid <= 0, E_flush <= 0; rst overrides stall and redirect.
REQ-027 First cycle after reset release shall fetch RESET_PC; D_valid becomes 1 on the following edge if not stalled or redirected.
REQ-028 Reset asserted mid-stall or mid-redirect shall discard that operation entirely.

Configuration
REQ-029 Macro FD_PERF_CNT_EN defined: add outputs fetch_cnt, stall_cnt, flush_cnt (32-bit each, reset to 0, wrap modulo 2^32) counting sequential, stall and redirect cycles respectively; exactly one increments per non-reset cycle.
REQ-030 Macro FD_PERF_CNT_EN undefined: these ports and counters shall not exist; all other behaviour is identical.

Verification
REQ-031 Reset, then 3 sequential cycles with im_rdata=32'h0010_0093 -> F_pc=12, D_pc=8, D_valid=1, D_out[4:0]=5'b00100, D_out[9:5]=1.
REQ-032 Stall held 2 cycles at F_pc=8 -> F_pc, D_inst, D_pc unchanged for both cycles; F_pc=12 on the first cycle after release.
REQ-033 next_pc_sel=0, jb_pc=32'h0000_0101 -> F_pc=32'h100, D_inst=32'h13, D_valid=0, E_flush=1 for exactly one cycle.
REQ-034 stall=1 and next_pc_sel=0 in the same cycle -> redirect behaviour as REQ-033; stall ignored.
REQ-035 F_pc=32'hFFFF_FFFC, sequential cycle -> F_pc=0, D_pc=32'hFFFF_FFFC; im_rdata=32'h0000_0000 -> D_illegal=1.
REQ-036 With FD_PERF_CNT_EN: 5 sequential, 2 stall, 1 redirect cycles -> fetch_cnt=5, stall_cnt=2, flush_cnt=1; rst -> all counters 0.
